// File: rtl/bfly_stage_param.sv
// rtl/bfly_stage_param.sv - radix-2 butterfly stage: lane add/sub, optional /2 rounding,
// block-programmable -j rotation on the difference path, saturation and block tracking.
module bfly_stage_param #(
  parameter int LANES   = 16,
  parameter int IN_W    = 9,
  parameter int OUT_W   = 10,
  parameter int BLK_CYC = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     valid_in,
  input  logic [LANES*IN_W-1:0]    in_a_real,
  input  logic [LANES*IN_W-1:0]    in_a_imag,
  input  logic [LANES*IN_W-1:0]    in_b_real,
  input  logic [LANES*IN_W-1:0]    in_b_imag,
  input  logic [1:0]               rot_mode,
  input  logic                     scale_en,
  input  logic                     clr_ovf,
  output logic                     valid_out,
  output logic [LANES*OUT_W-1:0]   out_add_real,
  output logic [LANES*OUT_W-1:0]   out_add_imag,
  output logic [LANES*OUT_W-1:0]   out_sub_real,
  output logic [LANES*OUT_W-1:0]   out_sub_imag,
  output logic                     blk_start,
  output logic                     blk_last,
  output logic                     ovf_sticky
);

  localparam int BW = $clog2(BLK_CYC);
  // Working width covers A-B, the +1 rounding term and negating the most-negative difference.
  localparam int EW = IN_W + 2;
  localparam int CW = ((EW > OUT_W) ? EW : OUT_W) + 1;

  typedef logic signed [CW-1:0] wide_t;

  localparam wide_t ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam wide_t SAT_MAX = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam wide_t SAT_MIN = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic wide_t sx(input logic [IN_W-1:0] x);
    return {{(CW-IN_W){x[IN_W-1]}}, x};
  endfunction

  function automatic wide_t scl(input wide_t v, input logic en);
    return en ? ((v + ONE) >>> 1) : v;
  endfunction

  function automatic logic clips(input wide_t v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic [OUT_W-1:0] sat(input wide_t v);
    if (v > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    else                  return v[OUT_W-1:0];
  endfunction

  logic [BW-1:0]            beat_cnt_q, beat_cnt_d;
  logic [1:0]               blk_rot_q, blk_rot_d;
  logic                     blk_scale_q, blk_scale_d;
  logic                     s1_valid_q, s1_valid_d;
  logic [LANES*IN_W-1:0]    s1_ar_q, s1_ar_d, s1_ai_q, s1_ai_d;
  logic [LANES*IN_W-1:0]    s1_br_q, s1_br_d, s1_bi_q, s1_bi_d;
  logic [BW-1:0]            s1_beat_q, s1_beat_d;
  logic [1:0]               s1_rot_q, s1_rot_d;
  logic                     s1_scale_q, s1_scale_d;
  logic                     valid_out_q, valid_out_d;
  logic                     blk_start_q, blk_start_d;
  logic                     blk_last_q, blk_last_d;
  logic                     ovf_q, ovf_d;
  logic [LANES*OUT_W-1:0]   add_re_q, add_re_d, add_im_q, add_im_d;
  logic [LANES*OUT_W-1:0]   sub_re_q, sub_re_d, sub_im_q, sub_im_d;

  logic                     first_beat;
  logic                     rot_flag;
  logic                     clip;
  logic [LANES*OUT_W-1:0]   res_add_re, res_add_im, res_sub_re, res_sub_im;

  always_comb begin
    first_beat  = (beat_cnt_q == '0);
    beat_cnt_d  = beat_cnt_q;
    blk_rot_d   = blk_rot_q;
    blk_scale_d = blk_scale_q;
    s1_valid_d  = valid_in;
    s1_ar_d     = s1_ar_q;
    s1_ai_d     = s1_ai_q;
    s1_br_d     = s1_br_q;
    s1_bi_d     = s1_bi_q;
    s1_beat_d   = s1_beat_q;
    s1_rot_d    = s1_rot_q;
    s1_scale_d  = s1_scale_q;
    if (valid_in) begin
      beat_cnt_d = beat_cnt_q + BW'(1);
      if (first_beat) begin
        blk_rot_d   = rot_mode;
        blk_scale_d = scale_en;
      end
      s1_ar_d    = in_a_real;
      s1_ai_d    = in_a_imag;
      s1_br_d    = in_b_real;
      s1_bi_d    = in_b_imag;
      s1_beat_d  = beat_cnt_q;
      // Beat 0 uses the freshly sampled config, later beats the latched one.
      s1_rot_d   = blk_rot_d;
      s1_scale_d = blk_scale_d;
    end
  end

  always_comb begin
    wide_t ar, ai, br, bi, s_re, s_im, d_re, d_im, r_re, r_im;
    ar = '0; ai = '0; br = '0; bi = '0;
    s_re = '0; s_im = '0; d_re = '0; d_im = '0; r_re = '0; r_im = '0;
    clip       = 1'b0;
    res_add_re = '0;
    res_add_im = '0;
    res_sub_re = '0;
    res_sub_im = '0;
    case (s1_rot_q)
      2'd1:    rot_flag = s1_beat_q[BW-1];
      2'd2:    rot_flag = s1_beat_q[BW-2];
      default: rot_flag = 1'b0;
    endcase
    for (int l = 0; l < LANES; l++) begin
      ar   = sx(s1_ar_q[l*IN_W +: IN_W]);
      ai   = sx(s1_ai_q[l*IN_W +: IN_W]);
      br   = sx(s1_br_q[l*IN_W +: IN_W]);
      bi   = sx(s1_bi_q[l*IN_W +: IN_W]);
      s_re = scl(ar + br, s1_scale_q);
      s_im = scl(ai + bi, s1_scale_q);
      d_re = scl(ar - br, s1_scale_q);
      d_im = scl(ai - bi, s1_scale_q);
      r_re = rot_flag ? d_im : d_re;
      r_im = rot_flag ? -d_re : d_im;
      res_add_re[l*OUT_W +: OUT_W] = sat(s_re);
      res_add_im[l*OUT_W +: OUT_W] = sat(s_im);
      res_sub_re[l*OUT_W +: OUT_W] = sat(r_re);
      res_sub_im[l*OUT_W +: OUT_W] = sat(r_im);
      clip = clip | clips(s_re) | clips(s_im) | clips(r_re) | clips(r_im);
    end
  end

  always_comb begin
    valid_out_d = s1_valid_q;
    blk_start_d = s1_valid_q && (s1_beat_q == '0);
    blk_last_d  = s1_valid_q && (s1_beat_q == BW'(BLK_CYC-1));
    // A new clamp in the same cycle as clr_ovf keeps the flag set.
    ovf_d       = (ovf_q & ~clr_ovf) | (s1_valid_q & clip);
    add_re_d    = s1_valid_q ? res_add_re : add_re_q;
    add_im_d    = s1_valid_q ? res_add_im : add_im_q;
    sub_re_d    = s1_valid_q ? res_sub_re : sub_re_q;
    sub_im_d    = s1_valid_q ? res_sub_im : sub_im_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt_q  <= '0;
      blk_rot_q   <= '0;
      blk_scale_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_ar_q     <= '0;
      s1_ai_q     <= '0;
      s1_br_q     <= '0;
      s1_bi_q     <= '0;
      s1_beat_q   <= '0;
      s1_rot_q    <= '0;
      s1_scale_q  <= 1'b0;
      valid_out_q <= 1'b0;
      blk_start_q <= 1'b0;
      blk_last_q  <= 1'b0;
      ovf_q       <= 1'b0;
      add_re_q    <= '0;
      add_im_q    <= '0;
      sub_re_q    <= '0;
      sub_im_q    <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      blk_rot_q   <= blk_rot_d;
      blk_scale_q <= blk_scale_d;
      s1_valid_q  <= s1_valid_d;
      s1_ar_q     <= s1_ar_d;
      s1_ai_q     <= s1_ai_d;
      s1_br_q     <= s1_br_d;
      s1_bi_q     <= s1_bi_d;
      s1_beat_q   <= s1_beat_d;
      s1_rot_q    <= s1_rot_d;
      s1_scale_q  <= s1_scale_d;
      valid_out_q <= valid_out_d;
      blk_start_q <= blk_start_d;
      blk_last_q  <= blk_last_d;
      ovf_q       <= ovf_d;
      add_re_q    <= add_re_d;
      add_im_q    <= add_im_d;
      sub_re_q    <= sub_re_d;
      sub_im_q    <= sub_im_d;
    end
  end

  assign valid_out    = valid_out_q;
  assign blk_start    = blk_start_q;
  assign blk_last     = blk_last_q;
  assign ovf_sticky   = ovf_q;
  assign out_add_real = add_re_q;
  assign out_add_imag = add_im_q;
  assign out_sub_real = sub_re_q;
  assign out_sub_imag = sub_im_q;

endmodule
